// File: rtl/ifu_pc.sv
// Fetch program-counter unit: PC register, next-PC selection, fetch-address fault and fetch counter.
// Define IFU_DELAY_SLOT_EN to enable MIPS branch-delay-slot sequencing and link_addr = pc+8.
`timescale 1ns/1ps
module ifu_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] link_addr,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  // One-past-the-end of the instruction memory, widened so it cannot wrap.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FAULT = 2'd1,
    ST_SLOT  = 2'd2
  } state_t;

  state_t             state;
  logic signed [31:0] imm_sx;
  logic signed [31:0] br_off;
  logic [31:0]        br_tgt;
  logic [31:0]        j_tgt;
  logic [31:0]        cand;
  logic               taken;
  logic               cand_ok;
  logic               seq_ok;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= IM_BASE) && ({1'b0, a} < IM_LIMIT);
  endfunction

  assign pc_plus4 = pc + 32'd4;
  assign imm_sx   = {{16{imm16[15]}}, imm16};
  assign br_off   = imm_sx <<< 2;
  assign br_tgt   = pc_plus4 + br_off;
  assign j_tgt    = {pc_plus4[31:28], instr_index, 2'b00};

`ifdef IFU_DELAY_SLOT_EN
  assign link_addr = pc + 32'd8;
`else
  assign link_addr = pc_plus4;
`endif

  always_comb begin
    taken = 1'b0;
    cand  = pc_plus4;
    unique case (npc_sel)
      2'b00: cand = pc_plus4;
      2'b01: begin
        taken = branch_taken;
        cand  = branch_taken ? br_tgt : pc_plus4;
      end
      2'b10: begin
        taken = 1'b1;
        cand  = j_tgt;
      end
      default: begin
        taken = 1'b1;
        cand  = jr_target;
      end
    endcase
  end

  assign cand_ok = addr_ok(cand);
  assign seq_ok  = addr_ok(pc_plus4);

`ifdef IFU_DELAY_SLOT_EN
  logic [31:0] pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      fault       <= 1'b0;
      fault_addr  <= 32'd0;
      fetch_count <= 32'd0;
      pending     <= 32'd0;
    end else if (!stall) begin
      unique case (state)
        ST_RUN: begin
          if (!cand_ok) begin
            fault      <= 1'b1;
            fault_addr <= cand;
            state      <= ST_FAULT;
          end else if (taken && !seq_ok) begin
            // Target is fine but the delay-slot fetch itself would leave memory.
            fault      <= 1'b1;
            fault_addr <= pc_plus4;
            state      <= ST_FAULT;
          end else if (taken) begin
            pending     <= cand;
            pc          <= pc_plus4;
            fetch_count <= fetch_count + 32'd1;
            state       <= ST_SLOT;
          end else begin
            pc          <= cand;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        ST_SLOT: begin
          pc          <= pending;
          fetch_count <= fetch_count + 32'd1;
          state       <= ST_RUN;
        end
        default: ;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      fault       <= 1'b0;
      fault_addr  <= 32'd0;
      fetch_count <= 32'd0;
    end else if (!stall) begin
      unique case (state)
        ST_RUN: begin
          if (cand_ok) begin
            pc          <= cand;
            fetch_count <= fetch_count + 32'd1;
          end else begin
            fault      <= 1'b1;
            fault_addr <= cand;
            state      <= ST_FAULT;
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule
